// File: rtl/shift_pkg.sv
// Shared types for the shift sequencer: FSM states, shift modes and direction codes.
// Rotate support is selected by SHIFT_SEQUENCER_ROTATE_EN in the sequencer.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_LOGICAL = 2'b00,
        MODE_ARITH   = 2'b01,
        MODE_ROTATE  = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift of a WIDTH-bit word with an explicit fill bit;
// reports the bit that falls off the end.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] data_out,
    output logic             shifted_out
);

    always_comb begin
        if (dir == DIR_LEFT) begin
            data_out    = {data_in[WIDTH-2:0], fill};
            shifted_out = data_in[WIDTH-1];
        end else begin
            data_out    = {fill, data_in[WIDTH-1:1]};
            shifted_out = data_in[0];
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-less shifter: one bit per clock, N cycles of latency.
// Define SHIFT_SEQUENCER_ROTATE_EN to enable mode 10 as rotate (otherwise logical).
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amount,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last_bit,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;
    mode_e            mode_q, mode_d;
    logic             msb_q, msb_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic             fill;
    logic [WIDTH-1:0] step_data;
    logic             step_out;

    // Arithmetic right replicates the MSB captured at accept, not the live one.
    always_comb begin
        fill = 1'b0;
        if (dir_q == DIR_RIGHT && mode_q == MODE_ARITH)
            fill = msb_q;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
        if (mode_q == MODE_ROTATE)
            fill = (dir_q == DIR_LEFT) ? data_q[WIDTH-1] : data_q[0];
`endif
    end

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data_in    (data_q),
        .dir        (dir_q),
        .fill       (fill),
        .data_out   (step_data),
        .shifted_out(step_out)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        msb_d   = msb_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    dir_d   = in_dir;
                    mode_d  = mode_e'(in_mode);
                    msb_d   = in_data[WIDTH-1];
                    cnt_d   = in_amount;
                    last_d  = 1'b0;
                    state_d = (in_amount == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = step_data;
                last_d = step_out;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1))
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Status outputs are registered, so derive them from the next state.
        valid_d = (state_d == DONE);
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            dir_q   <= DIR_LEFT;
            mode_q  <= MODE_LOGICAL;
            msb_q   <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            msb_q   <= msb_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign in_ready     = ready_q;
    assign out_valid    = valid_q;
    assign out_data     = data_q;
    assign out_last_bit = last_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: arithmetic reference model plus directed vectors.
module tb_shift_sequencer;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [AW-1:0] in_amount = '0;
    logic          in_dir = 1'b0;
    logic [1:0]    in_mode = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_last_bit;
    logic          busy;

    int tests = 0;
    int fails = 0;

    shift_sequencer #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_amount   (in_amount),
        .in_dir      (in_dir),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last_bit(out_last_bit),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef SHIFT_SEQUENCER_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    // Reference result straight from the shift definitions.
    function automatic void ref_shift(input logic [W-1:0] d, input int n, input logic dir,
                                      input logic [1:0] mode,
                                      output logic [W-1:0] r, output logic last);
        bit rot;
        rot = ROT && (mode == 2'b10);
        if (n == 0) begin
            r = d;
            last = 1'b0;
        end else if (dir == 1'b0) begin
            r = d << n;
            last = d[W-n];
            if (rot) r = r | (d >> (W - n));
        end else begin
            last = d[n-1];
            if (mode == 2'b01) r = W'($signed(d) >>> n);
            else               r = d >> n;
            if (rot) r = r | (d << (W - n));
        end
    endfunction

    // Transaction-level model: busy from accept until consumed, valid N cycles after accept.
    logic         m_busy = 1'b0;
    logic         m_valid = 1'b0;
    int           m_wait = 0;
    logic [W-1:0] m_data = '0;
    logic         m_last = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_wait  = 0;
            m_data  = '0;
            m_last  = 1'b0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
            end
        end else if (m_busy) begin
            m_wait--;
            if (m_wait == 0) m_valid = 1'b1;
        end else if (in_valid) begin
            m_busy = 1'b1;
            m_wait = int'(in_amount);
            ref_shift(in_data, int'(in_amount), in_dir, in_mode, m_data, m_last);
            if (m_wait == 0) m_valid = 1'b1;
        end
    end

    bit check_en = 1'b0;

    always @(negedge clk) begin
        if (rst_n && check_en) begin
            chk("cyc_out_valid", W'(out_valid), W'(m_valid));
            chk("cyc_in_ready", W'(in_ready), W'(!m_busy));
            chk("cyc_busy", W'(busy), W'(m_busy));
            if (m_valid) begin
                chk("cyc_out_data", out_data, m_data);
                chk("cyc_last_bit", W'(out_last_bit), W'(m_last));
            end
        end
    end

    task automatic do_op(input string name, input logic [W-1:0] d, input int n, input logic dir,
                         input logic [1:0] mode, input int hold, input bit pin,
                         input logic [W-1:0] exp_d, input logic exp_l);
        int cyc;
        int lat;
        @(posedge clk);
        #2;
        in_data   = d;
        in_amount = AW'(n);
        in_dir    = dir;
        in_mode   = mode;
        in_valid  = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!m_busy && cyc < 50);
        in_valid  = 1'b0;
        in_data   = $urandom;
        in_amount = AW'($urandom);
        in_dir    = 1'($urandom);
        in_mode   = 2'($urandom);
        if (!m_busy) begin
            chk({name, "_accept_timeout"}, 0, 1);
            return;
        end
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            chk({name, "_valid_timeout"}, 0, 1);
            return;
        end
        if (pin) begin
            chk({name, "_latency"}, W'(lat), W'(n));
            chk({name, "_data"}, out_data, exp_d);
            chk({name, "_last"}, W'(out_last_bit), W'(exp_l));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (pin) begin
                chk({name, "_hold_data"}, out_data, exp_d);
                chk({name, "_hold_ready"}, W'(in_ready), 0);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int vcount;
        logic [W-1:0] rd;
        logic [W-1:0] rot_exp;
        #12;
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_last_bit", W'(out_last_bit), 0);
        chk("rst_busy", W'(busy), 0);
        chk("rst_in_ready", W'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        check_en = 1'b1;

        do_op("left_log4", 32'h0000_0001, 4, 1'b0, 2'b00, 0, 1'b1, 32'h0000_0010, 1'b0);
        do_op("right_ari3", 32'h8000_0000, 3, 1'b1, 2'b01, 0, 1'b1, 32'hF000_0000, 1'b0);
        do_op("right_log3", 32'h8000_0000, 3, 1'b1, 2'b00, 0, 1'b1, 32'h1000_0000, 1'b0);
        do_op("right_rsv3", 32'h8000_0000, 3, 1'b1, 2'b11, 0, 1'b1, 32'h1000_0000, 1'b0);
        rot_exp = ROT ? 32'h0000_0003 : 32'h0000_0002;
        do_op("left_rot1", 32'h8000_0001, 1, 1'b0, 2'b10, 0, 1'b1, rot_exp, 1'b1);
        do_op("zero_amt", 32'hDEAD_BEEF, 0, 1'b0, 2'b00, 5, 1'b1, 32'hDEAD_BEEF, 1'b0);
        do_op("left_ari2", 32'hC000_0001, 2, 1'b0, 2'b01, 1, 1'b1, 32'h0000_0004, 1'b1);
        do_op("right_log31", 32'h8000_0001, 31, 1'b1, 2'b00, 0, 1'b1, 32'h0000_0001, 1'b0);

        // Abort a long shift partway through with reset.
        @(posedge clk);
        #2;
        in_data = 32'h1234_5678; in_amount = AW'(20); in_dir = 1'b0; in_mode = 2'b00;
        in_valid = 1'b1;
        vcount = 0;
        while (!m_busy && vcount < 50) begin
            @(negedge clk);
            vcount++;
        end
        in_valid = 1'b0;
        chk("abort_accepted", W'(m_busy), 1);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", W'(out_valid), 0);
        chk("abort_in_ready", W'(in_ready), 1);
        chk("abort_busy", W'(busy), 0);
        chk("abort_out_data", out_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        chk("abort_no_valid", W'(vcount), 0);
        do_op("post_abort", 32'h0000_00F0, 8, 1'b1, 2'b00, 0, 1'b1, 32'h0000_0000, 1'b1);

        do_op("v_rot_r4", 32'hF000_000F, 4, 1'b1, 2'b10, 0, 1'b0, '0, 1'b0);
        do_op("v_ari_r31", 32'h8765_4321, 31, 1'b1, 2'b01, 2, 1'b0, '0, 1'b0);
        do_op("v_log_l31", 32'h1234_5679, 31, 1'b0, 2'b00, 0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rd = $urandom;
            do_op("v_rand", rd, int'($urandom_range(0, 31)), 1'($urandom),
                  2'($urandom), int'($urandom_range(0, 3)), 1'b0, '0, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter AMT_W, default 5, shift-amount width, equal to log2(WIDTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 SHALL have port in_data, input, WIDTH, operand.
REQ-008 SHALL have port in_amount, input, AMT_W, shift count N (0..WIDTH-1).
REQ-009 SHALL have port in_dir, input, 1, direction: 0 = left, 1 = right.
REQ-010 SHALL have port in_mode, input, 2, mode: 00 logical, 01 arithmetic, 10 rotate, 11 reserved.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-013 SHALL have port out_data, output, WIDTH, shifted result.
REQ-014 SHALL have port out_last_bit, output, 1, last bit shifted out of the operand.
REQ-015 SHALL have port busy, output, 1, high in SHIFT or DONE.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; accept is in_valid && in_ready.
REQ-018 On accept at edge k SHALL register in_data, in_dir and in_mode, and load counter = in_amount; next state is DONE if N = 0, else SHIFT.
REQ-019 In SHIFT SHALL perform exactly one 1-bit shift per edge and decrement the counter; SHALL move to DONE on the edge where the counter reaches 0.
REQ-020 out_valid SHALL be high in DONE only, first visible after edge k+N (latency N cycles; N = 0 gives the result the cycle after accept).
REQ-021 Left shifts SHALL fill bit 0 with 0 in logical and arithmetic modes.
REQ-022 Logical right SHALL fill the MSB with 0; arithmetic right SHALL fill it with the operand's original MSB on every step.
REQ-023 Rotate SHALL fill the vacated bit with the bit shifted out in the same step.
REQ-024 Mode 11 SHALL behave as logical.
REQ-025 out_last_bit SHALL equal the bit shifted out on the final step (pre-step bit WIDTH-1 for left, bit 0 for right), and 0 when N = 0.
REQ-026 For N = 0, out_data SHALL equal in_data unchanged.
REQ-027 In DONE, out_data and out_last_bit SHALL hold stable until out_valid && out_ready, then the FSM SHALL return to IDLE; no new accept in that same cycle.
REQ-028 Input changes while busy SHALL be ignored; in_valid while busy SHALL NOT be dropped, but held off by in_ready = 0.
REQ-029 SHALL NOT be combinationally dependent on out_ready for in_ready.

Reset
REQ-030 rst_n low SHALL force IDLE immediately, regardless of state, aborting any operation in progress with no partial result emitted.
REQ-031 Reset values SHALL be: out_valid 0, out_data 0, out_last_bit 0, busy 0, in_ready 1, counter 0.

Configuration
REQ-032 Macro SHIFT_SEQUENCER_ROTATE_EN SHALL control rotate support: defined gives mode 10 = rotate; undefined makes mode 10 behave as logical, with no rotate feedback logic synthesised.

Structure
REQ-033 Package shift_pkg SHALL hold the state enum (IDLE/SHIFT/DONE), the mode enum and the DIR_LEFT/DIR_RIGHT constants.
REQ-034 SHALL instantiate one combinational sub-module shift_step (1-bit shift of WIDTH bits with a fill-bit input and a shifted-out-bit output); the FSM, counter and registers stay in shift_sequencer.

Verification
REQ-035 0x0000_0001, N = 4, left, logical -> out_data 0x0000_0010, last_bit 0, out_valid 4 cycles after accept.
REQ-036 0x8000_0000, N = 3, right, arithmetic -> 0xF000_0000, last_bit 0; same operand with logical mode -> 0x1000_0000.
REQ-037 0x8000_0001, N = 1, left, rotate -> 0x0000_0003, last_bit 1; with macro undefined -> 0x0000_0002.
REQ-038 0xDEAD_BEEF, N = 0 -> 0xDEAD_BEEF one cycle after accept; out_ready held low 5 cycles -> output stable and in_ready 0 throughout.
REQ-039 rst_n low mid-SHIFT (N = 20, after 7 steps) -> IDLE, out_valid never asserted, next request completes correctly.
